// File: rtl/cache_fill_arbiter_pkg.sv
// Shared types and default sizing for the cache fill arbiter slice.
// State and owner encodings live here so the top and any future users agree.
package cache_fill_arbiter_pkg;

  localparam int WORDS_DEF       = 8;
  localparam int MEM_LATENCY_DEF = 4;
  localparam int WORD_IDX_W      = $clog2(WORDS_DEF);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    FILL,
    DONE
  } state_t;

  typedef enum logic {
    OWN_I,
    OWN_D
  } owner_t;

endpackage

// File: rtl/cache_fill_arbiter_word_counter.sv
// Word index counter with synchronous clear, count enable and terminal count.
// Wraps naturally at WIDTH bits, so terminal count means index WORDS-1.
module fill_word_counter
  import cache_fill_arbiter_pkg::*;
#(
  parameter int WIDTH = WORD_IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == {WIDTH{1'b1}});

endmodule

// File: rtl/cache_fill_arbiter.sv
// Arbitrates I/D cache block fills and D-cache write-through stores onto one
// shared memory port; fill data is streamed combinationally into the owning cache.
module cache_fill_arbiter
  import cache_fill_arbiter_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int WORDS       = WORDS_DEF,
  parameter int MEM_LATENCY = MEM_LATENCY_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_miss,
  input  logic [ADDR_W-1:0]        i_miss_addr,
  input  logic                     d_miss,
  input  logic [ADDR_W-1:0]        d_miss_addr,
  input  logic                     d_wr_req,
  input  logic [ADDR_W-1:0]        d_wr_addr,
  input  logic [DATA_W-1:0]        d_wr_data,
  output logic                     d_wr_ack,
  output logic [DATA_W-1:0]        fill_data,
  output logic [$clog2(WORDS)-1:0] fill_word,
  output logic                     i_fill_we,
  output logic                     d_fill_we,
  output logic                     i_fill_done,
  output logic                     d_fill_done,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_data_out,
  output logic                     mem_enable,
  output logic                     mem_wr,
  input  logic [DATA_W-1:0]        mem_data_in,
  input  logic                     mem_data_valid,
  output logic                     busy
);

  localparam int IDX_W = $clog2(WORDS);
  localparam int OFF_W = IDX_W + 1;
  localparam logic [ADDR_W-1:0] BASE_MASK = {ADDR_W{1'b1}} << OFF_W;

  if ((WORDS < 2) || ((WORDS & (WORDS - 1)) != 0)) begin : g_bad_words
    $error("cache_fill_arbiter: WORDS must be a power of two >= 2");
  end
  if (MEM_LATENCY < 1) begin : g_bad_latency
    $error("cache_fill_arbiter: MEM_LATENCY must be at least 1");
  end

  state_t            state;
  owner_t            owner;
  logic [ADDR_W-1:0] base;
  logic [IDX_W-1:0]  issue_cnt;
  logic [IDX_W-1:0]  recv_cnt;
  logic              issue_tc;
  logic              recv_tc;
  logic              clear_cnt;
  logic              issue_en;
  logic              fill_active;

  assign clear_cnt   = (state != FILL);
  assign issue_en    = (state == FILL) && mem_enable;
  assign fill_active = (state == FILL) && mem_data_valid;

  fill_word_counter #(.WIDTH(IDX_W)) u_issue_cnt (
    .clk    (clk),
    .rst    (rst),
    .clear  (clear_cnt),
    .enable (issue_en),
    .count  (issue_cnt),
    .tc     (issue_tc)
  );

  fill_word_counter #(.WIDTH(IDX_W)) u_recv_cnt (
    .clk    (clk),
    .rst    (rst),
    .clear  (clear_cnt),
    .enable (fill_active),
    .count  (recv_cnt),
    .tc     (recv_tc)
  );

  // Returned words bypass the FSM so each valid lands in the cache the same cycle.
  assign fill_data = fill_active ? mem_data_in : '0;
  assign fill_word = recv_cnt;
  assign i_fill_we = fill_active && (owner == OWN_I);
  assign d_fill_we = fill_active && (owner == OWN_D);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      owner        <= OWN_I;
      base         <= '0;
      mem_enable   <= 1'b0;
      mem_wr       <= 1'b0;
      mem_addr     <= '0;
      mem_data_out <= '0;
      d_wr_ack     <= 1'b0;
      i_fill_done  <= 1'b0;
      d_fill_done  <= 1'b0;
      busy         <= 1'b0;
    end else begin
      d_wr_ack    <= 1'b0;
      i_fill_done <= 1'b0;
      d_fill_done <= 1'b0;
      case (state)
        IDLE: begin
          mem_enable <= 1'b0;
          mem_wr     <= 1'b0;
          if (d_wr_req) begin
            state        <= WRITE;
            busy         <= 1'b1;
            mem_enable   <= 1'b1;
            mem_wr       <= 1'b1;
            mem_addr     <= d_wr_addr;
            mem_data_out <= d_wr_data;
            d_wr_ack     <= 1'b1;
          end else if (d_miss) begin
            state      <= FILL;
            owner      <= OWN_D;
            busy       <= 1'b1;
            base       <= d_miss_addr & BASE_MASK;
            mem_enable <= 1'b1;
            mem_addr   <= d_miss_addr & BASE_MASK;
          end else if (i_miss) begin
            state      <= FILL;
            owner      <= OWN_I;
            busy       <= 1'b1;
            base       <= i_miss_addr & BASE_MASK;
            mem_enable <= 1'b1;
            mem_addr   <= i_miss_addr & BASE_MASK;
          end
        end
        WRITE: begin
          state      <= IDLE;
          busy       <= 1'b0;
          mem_enable <= 1'b0;
          mem_wr     <= 1'b0;
        end
        FILL: begin
          // mem_addr is prepared one word ahead since the port outputs are registered.
          if (mem_enable) begin
            if (issue_tc) begin
              mem_enable <= 1'b0;
            end else begin
              mem_addr <= base + ADDR_W'({issue_cnt + 1'b1, 1'b0});
            end
          end
          if (fill_active && recv_tc) begin
            state <= DONE;
            if (owner == OWN_I) begin
              i_fill_done <= 1'b1;
            end else begin
              d_fill_done <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Randomized scoreboard bench for cache_fill_arbiter with a latency-4 memory model
// and a transaction-level arbitration model predicting grant order and timing.
module tb_cache_fill_arbiter;

  localparam int LAT   = 4;
  localparam int NWORD = 8;
  localparam int K_WR  = 0;
  localparam int K_FILL = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_miss, d_miss, d_wr_req;
  logic [15:0] i_miss_addr, d_miss_addr, d_wr_addr, d_wr_data;
  logic        d_wr_ack;
  logic [15:0] fill_data;
  logic [2:0]  fill_word;
  logic        i_fill_we, d_fill_we, i_fill_done, d_fill_done;
  logic [15:0] mem_addr, mem_data_out;
  logic        mem_enable, mem_wr;
  logic [15:0] mem_data_in = 16'h0;
  logic        mem_data_valid = 1'b0;
  logic        busy;

  cache_fill_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .i_miss         (i_miss),
    .i_miss_addr    (i_miss_addr),
    .d_miss         (d_miss),
    .d_miss_addr    (d_miss_addr),
    .d_wr_req       (d_wr_req),
    .d_wr_addr      (d_wr_addr),
    .d_wr_data      (d_wr_data),
    .d_wr_ack       (d_wr_ack),
    .fill_data      (fill_data),
    .fill_word      (fill_word),
    .i_fill_we      (i_fill_we),
    .d_fill_we      (d_fill_we),
    .i_fill_done    (i_fill_done),
    .d_fill_done    (d_fill_done),
    .mem_addr       (mem_addr),
    .mem_data_out   (mem_data_out),
    .mem_enable     (mem_enable),
    .mem_wr         (mem_wr),
    .mem_data_in    (mem_data_in),
    .mem_data_valid (mem_data_valid),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  int flush_gen = 0;
  bit spur = 1'b0;

  typedef struct {
    int          kind;
    bit          owner_d;
    logic [15:0] addr;
    logic [15:0] data;
    int          start;
  } tx_t;

  typedef struct {
    int          due;
    logic [15:0] data;
  } rd_t;

  tx_t exp_q[$];
  rd_t rd_q[$];

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory: each read returns LAT cycles after its issue cycle, in order.
  always @(negedge clk) begin
    rd_t r;
    if (mem_enable && !mem_wr) begin
      r.due  = cyc + LAT;
      r.data = mem_word(mem_addr);
      rd_q.push_back(r);
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
        mem_data_valid = 1'b1;
        mem_data_in    = rd_q[0].data;
        void'(rd_q.pop_front());
      end else if (spur) begin
        mem_data_valid = 1'b1;
        mem_data_in    = 16'($urandom);
      end else begin
        mem_data_valid = 1'b0;
        mem_data_in    = 16'($urandom);
      end
    end
  end

  // Monitor: pops the predicted transaction on its first memory access.
  tx_t         cur;
  bit          cur_active = 1'b0;
  int          nrd, nrx;
  int          seen_flush = 0;
  logic [15:0] cbase;

  always @(negedge clk) begin
    if (flush_gen != seen_flush) begin
      seen_flush = flush_gen;
      exp_q.delete();
      cur_active = 1'b0;
    end
    if (mem_enable) begin
      if (!cur_active) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_mem_access", 1, 0);
        end else begin
          cur = exp_q.pop_front();
          cur_active = 1'b1;
          nrd = 0;
          nrx = 0;
          cbase = cur.addr & 16'hFFF0;
        end
      end
      if (cur_active) begin
        if (cur.kind == K_WR) begin
          checkOutput("wr_cycle", cyc, cur.start + 1);
          checkOutput("wr_mem_wr", mem_wr, 1);
          checkOutput("wr_addr", mem_addr, cur.addr);
          checkOutput("wr_data", mem_data_out, cur.data);
          checkOutput("wr_ack", d_wr_ack, 1);
          cur_active = 1'b0;
        end else if (nrd >= NWORD) begin
          checkOutput("extra_read", nrd, NWORD - 1);
        end else begin
          checkOutput("rd_cycle", cyc, cur.start + 1 + nrd);
          checkOutput("rd_mem_wr", mem_wr, 0);
          checkOutput("rd_addr", mem_addr, cbase + 16'(2 * nrd));
          nrd++;
        end
      end
    end else if (d_wr_ack) begin
      checkOutput("ack_without_write", d_wr_ack, 0);
    end
    if (i_fill_we || d_fill_we) begin
      if (!cur_active || cur.kind != K_FILL) begin
        checkOutput("unexpected_fill_we", 1, 0);
      end else begin
        checkOutput("fill_cycle", cyc, cur.start + 1 + LAT + nrx);
        checkOutput("fill_i_we", i_fill_we, !cur.owner_d);
        checkOutput("fill_d_we", d_fill_we, cur.owner_d);
        checkOutput("fill_word", fill_word, nrx[2:0]);
        checkOutput("fill_data", fill_data, mem_word(cbase + 16'(2 * nrx)));
        nrx++;
      end
    end
    if (i_fill_done || d_fill_done) begin
      if (!cur_active || cur.kind != K_FILL) begin
        checkOutput("unexpected_done", 1, 0);
      end else begin
        checkOutput("done_cycle", cyc, cur.start + 13);
        checkOutput("done_words", nrx, NWORD);
        checkOutput("done_i", i_fill_done, !cur.owner_d);
        checkOutput("done_d", d_fill_done, cur.owner_d);
        cur_active = 1'b0;
      end
    end
    if (cur_active) checkOutput("busy_in_tx", busy, 1);
  end

  // Predicts grant order from "highest pending request wins whenever idle",
  // then drives the requests as level signals held until their completion.
  task automatic applyStimulus(input bit we, input bit de, input bit ie,
                               input int ow, input int od, input int oi,
                               input logic [15:0] wa, input logic [15:0] wd,
                               input logic [15:0] da, input logic [15:0] ia);
    int  st[3];
    bit  en[3];
    bit  served[3];
    bit  fin[3];
    bit  drop[3];
    int  free, g, minst, win;
    bit  all_fin;
    tx_t t;
    en[0] = we; en[1] = de; en[2] = ie;
    st[0] = cyc + ow; st[1] = cyc + od; st[2] = cyc + oi;
    free = cyc;
    for (int j = 0; j < 3; j++) begin
      served[j] = 1'b0; fin[j] = !en[j]; drop[j] = 1'b0;
    end
    forever begin
      minst = -1;
      for (int j = 0; j < 3; j++)
        if (en[j] && !served[j] && (minst < 0 || st[j] < minst)) minst = st[j];
      if (minst < 0) break;
      g = (minst > free) ? minst : free;
      win = -1;
      for (int j = 2; j >= 0; j--)
        if (en[j] && !served[j] && st[j] <= g) win = j;
      served[win] = 1'b1;
      t.kind    = (win == 0) ? K_WR : K_FILL;
      t.owner_d = (win == 1);
      t.addr    = (win == 0) ? wa : (win == 1) ? da : ia;
      t.data    = wd;
      t.start   = g;
      exp_q.push_back(t);
      free = g + ((win == 0) ? 2 : 14);
    end
    all_fin = 1'b0;
    for (int k = 0; k < 400 && !all_fin; k++) begin
      if (drop[0]) begin d_wr_req = 1'b0; drop[0] = 1'b0; end
      if (drop[1]) begin d_miss   = 1'b0; drop[1] = 1'b0; end
      if (drop[2]) begin i_miss   = 1'b0; drop[2] = 1'b0; end
      if (en[0] && cyc == st[0]) begin d_wr_req = 1'b1; d_wr_addr = wa; d_wr_data = wd; end
      if (en[1] && cyc == st[1]) begin d_miss = 1'b1; d_miss_addr = da; end
      if (en[2] && cyc == st[2]) begin i_miss = 1'b1; i_miss_addr = ia; end
      @(negedge clk);
      if (d_wr_ack    && !fin[0]) begin fin[0] = 1'b1; drop[0] = 1'b1; end
      if (d_fill_done && !fin[1]) begin fin[1] = 1'b1; drop[1] = 1'b1; end
      if (i_fill_done && !fin[2]) begin fin[2] = 1'b1; drop[2] = 1'b1; end
      all_fin = fin[0] && fin[1] && fin[2];
      @(posedge clk);
      #1;
    end
    d_wr_req = 1'b0; d_miss = 1'b0; i_miss = 1'b0;
    checkOutput("round_complete", all_fin, 1);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("tx_left", exp_q.size(), 0);
  endtask

  initial begin
    tx_t t;
    int  tstart;
    rst = 1'b1;
    i_miss = 1'b0; d_miss = 1'b0; d_wr_req = 1'b0;
    i_miss_addr = '0; d_miss_addr = '0; d_wr_addr = '0; d_wr_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_mem_enable", mem_enable, 0);
    checkOutput("rst_mem_wr", mem_wr, 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    checkOutput("rst_mem_data_out", mem_data_out, 0);
    checkOutput("rst_ack", d_wr_ack, 0);
    checkOutput("rst_fill_we", {i_fill_we, d_fill_we}, 0);
    checkOutput("rst_done", {i_fill_done, d_fill_done}, 0);
    checkOutput("rst_fill_data", fill_data, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] I-cache fill of 0x1234");
    applyStimulus(0, 0, 1, 0, 0, 0, 16'h0, 16'h0, 16'h0, 16'h1234);
    $display("[TB] simultaneous D and I miss");
    applyStimulus(0, 1, 1, 0, 0, 0, 16'h0, 16'h0, 16'h8000, 16'h0040);
    $display("[TB] store during I fill");
    applyStimulus(1, 0, 1, 3, 0, 0, 16'h2002, 16'hBEEF, 16'h0, 16'h4010);
    $display("[TB] simultaneous store and D miss");
    applyStimulus(1, 1, 0, 0, 0, 0, 16'h6006, 16'h1357, 16'h9A74, 16'h0);

    $display("[TB] reset in the middle of a fill");
    tstart = cyc;
    i_miss = 1'b1; i_miss_addr = 16'h3456;
    t.kind = K_FILL; t.owner_d = 1'b0; t.addr = 16'h3456; t.data = '0; t.start = tstart;
    exp_q.push_back(t);
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    i_miss = 1'b0;
    flush_gen++;
    @(negedge clk);
    checkOutput("post_rst_busy", busy, 0);
    checkOutput("post_rst_mem_enable", mem_enable, 0);
    repeat (10) @(posedge clk);
    #1;
    checkOutput("post_rst_idle", busy, 0);
    applyStimulus(0, 0, 1, 0, 0, 0, 16'h0, 16'h0, 16'h0, 16'h3456);

    $display("[TB] stray memory valids while idle");
    @(negedge clk);
    spur = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checkOutput("spur_busy", busy, 0);
      checkOutput("spur_fill_we", {i_fill_we, d_fill_we}, 0);
    end
    spur = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] randomized rounds");
    for (int r = 0; r < 20; r++) begin
      logic [2:0] m;
      m = 3'($urandom_range(1, 7));
      applyStimulus(m[0], m[1], m[2],
                    int'($urandom_range(0, 20)), int'($urandom_range(0, 20)),
                    int'($urandom_range(0, 20)),
                    16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_fill_arbiter.md
Name: cache_fill_arbiter

Overview:
- Sits between the I-cache/D-cache and the single shared multi-cycle main memory.
- Arbitrates I-cache miss fills, D-cache miss fills and D-cache write-through stores onto one memory port.
- On a miss, issues one read per word of the 16-byte block and streams the returned words back into the owning cache.
- Holds everything else off (cache stall stays asserted) until the fill or store completes.

Parameters:
- ADDR_W, 16, byte-address width.
- DATA_W, 16, word width.
- WORDS, 8, words per cache block (must be a power of 2; word index width = log2(WORDS)).
- MEM_LATENCY, 4, cycles from a read issue to its mem_data_valid.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- i_miss  in  1  I-cache miss request; held level until i_fill_done.
- i_miss_addr  in  ADDR_W  I-cache missing byte address.
- d_miss  in  1  D-cache miss request; held until d_fill_done.
- d_miss_addr  in  ADDR_W  D-cache missing byte address.
- d_wr_req  in  1  D-cache write-through store request; held until d_wr_ack.
- d_wr_addr  in  ADDR_W  store byte address.
- d_wr_data  in  DATA_W  store data.
- d_wr_ack  out  1  one-cycle pulse when the store is issued to memory.
- fill_data  out  DATA_W  returned word (shared by both caches).
- fill_word  out  log2(WORDS)  word index within the block for fill_data.
- i_fill_we  out  1  write fill_data into the I-cache this cycle.
- d_fill_we  out  1  write fill_data into the D-cache this cycle.
- i_fill_done  out  1  one-cycle pulse: I-cache block complete.
- d_fill_done  out  1  one-cycle pulse: D-cache block complete.
- mem_addr  out  ADDR_W  memory address.
- mem_data_out  out  DATA_W  memory write data.
- mem_enable  out  1  memory access this cycle.
- mem_wr  out  1  memory write (valid with mem_enable).
- mem_data_in  in  DATA_W  memory read data.
- mem_data_valid  in  1  mem_data_in valid.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: state=IDLE, owner=I, counters=0. All outputs 0, except fill_data and mem_addr, which are 0 (don't-care when their strobes are low).
- States:
  - IDLE, WRITE, FILL, DONE.
  - IDLE priority: d_wr_req > d_miss > i_miss.
  - The winner's address is latched; block base = addr with the low log2(WORDS)+1 bits cleared.
  - d_wr_req → WRITE; d_miss → FILL with owner=D; i_miss → FILL with owner=I.
- WRITE (1 cycle):
  - mem_enable=1, mem_wr=1, mem_addr=latched d_wr_addr, mem_data_out=latched data.
  - d_wr_ack=1. Next state IDLE.
- FILL:
  - Issue counter runs 0..WORDS-1. While issue_cnt<WORDS: mem_enable=1, mem_wr=0, mem_addr=base+2*issue_cnt; issue_cnt increments each cycle.
  - Each cycle mem_data_valid=1: fill_data=mem_data_in, fill_word=recv_cnt, owner's fill_we=1; recv_cnt increments.
  - Receiving the last word (recv_cnt=WORDS-1 with valid) → DONE.
- DONE (1 cycle): owner's *_fill_done=1; counters cleared; next state IDLE.
- Timing (defaults): request seen in IDLE at cycle T.
  - Issues at T+1..T+8; valids at T+5..T+12.
  - done at T+13; IDLE at T+14, when a new grant is possible.
- Requests arriving while busy are not granted until IDLE. A request that drops before its grant is simply not served.
- mem_data_valid outside FILL is ignored (no fill_we).
- Same-cycle requests: the lower-priority requester waits its turn, with no starvation beyond one transaction per grant.
- Memory returns reads in issue order, exactly one valid per read. Extra valids after recv_cnt reaches WORDS are ignored.
- Reset mid-FILL/WRITE: IDLE next cycle; no done or ack pulse; partial fill abandoned.
- Address arithmetic is ADDR_W-bit and never carries out of the block (base aligned).

Decomposition:
- Shared package: state enum (IDLE/WRITE/FILL/DONE), owner enum (OWN_I/OWN_D), WORDS and MEM_LATENCY defaults, word-index width constant.
- One sub-module: fill_word_counter (log2(WORDS)-bit counter with clear/enable/terminal-count), instantiated twice (issue, receive).

Test Plan:
- i_miss=1, i_miss_addr=0x1234 → mem reads 0x1230,0x1232,…,0x123E on consecutive cycles. i_fill_we with fill_word 0..7 carrying the memory model data. i_fill_done pulse at T+13; d_* outputs stay 0.
- i_miss and d_miss asserted in the same cycle (addrs 0x0040, 0x8000) → D block 0x8000..0x800E filled first with d_fill_done. The I fill of 0x0040 starts in the cycle after IDLE is re-entered.
- d_wr_req (addr 0x2002, data 0xBEEF) during an I fill → waits. After i_fill_done: one cycle with mem_wr=1, mem_addr=0x2002, mem_data_out=0xBEEF, d_wr_ack=1.
- d_wr_req and d_miss simultaneous → WRITE first (1 cycle), then D fill.
- rst asserted at T+7 of a fill → IDLE next cycle. No fill_done; late valids produce no fill_we. A fresh i_miss then completes normally.
- mem_data_valid pulsed while IDLE → no fill_we, busy stays 0.
